// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit fed by the ALU result (address) and rs2 (store
// data); runs one data-memory access per start over a mem_req/mem_ack pair.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request pulse, sampled only in IDLE
//   is_store, funct3  access kind and RISC-V width/sign field
//   addr, wdata       effective address and store data
//   busy, done, err   stall, one-cycle completion, error (valid with done)
//   rdata_out         formatted load result
//   misaligned        misalignment flag (valid with done)
//   mem_*             data-memory request side
//
// Macro LSU_MISALIGN_CHECK_EN: when defined, misaligned half/word accesses
// complete with err/misaligned and issue no request; when undefined the
// offending low address bits are dropped and the access proceeds.
module riscv_lsu #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata_out,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   cnt;

  logic            is_byte;
  logic            is_half;
  logic            legal;
  logic            mis;
  logic [1:0]      o;
  logic [1:0]      eo;
  logic [3:0]      be_n;
  logic [31:0]     wd_n;

  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [31:0]     fmt;

  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);
  assign o       = addr[1:0];

  // Loads: 000,001,010,100,101. Stores: 000,001,010.
  assign legal = is_store
    ? (!funct3[2] && funct3[1:0] != 2'b11)
    : (funct3[1:0] != 2'b11 && funct3 != 3'b110);

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (is_half && o[0]) ||
               (funct3[1:0] == 2'b10 && o != 2'b00);
  assign eo  = o;
`else
  // Misalignment is never reported; drop the bits below the access size.
  assign mis = 1'b0;
  assign eo  = is_byte ? o :
               is_half ? {o[1], 1'b0} : 2'b00;
`endif

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    unique case (1'b1)
      is_byte: begin
        be_n = 4'b0001 << eo;
        wd_n = {4{wdata[7:0]}};
      end
      is_half: begin
        be_n = 4'b0011 << {eo[1], 1'b0};
        wd_n = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    if (!is_store) wd_n = '0;
  end

  // Load lane select uses the offset latched at start.
  assign lb = mem_rdata[{off_q, 3'b000} +: 8];
  assign lh = mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    fmt = mem_rdata;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00): fmt = {{24{lb[7] & ~f3_q[2]}}, lb};
      (f3_q[1:0] == 2'b01): fmt = {{16{lh[15] & ~f3_q[2]}}, lh};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      st_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      misaligned <= 1'b0;
      rdata_out  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            st_q  <= is_store;
            f3_q  <= funct3;
            off_q <= eo;
            cnt   <= '0;
            busy  <= 1'b1;
            if (!legal || mis) begin
              state      <= DONE;
              done       <= 1'b1;
              err        <= 1'b1;
              misaligned <= legal & mis;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wd_n;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!st_q) rdata_out <= fmt;
            state     <= DONE;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else if (ACK_TIMEOUT > 0 &&
                       cnt == CW'(ACK_TIMEOUT - 1)) begin
            state     <= DONE;
            done      <= 1'b1;
            err       <= 1'b1;
            rdata_out <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else if (ACK_TIMEOUT > 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
          misaligned <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized and directed self-checking bench for riscv_lsu
// against a byte-lane reference model.
module tb_riscv_lsu;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata_out;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  riscv_lsu #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata_out(rdata_out),
    .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_at;
    int          nreq;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    bit          stable;
    bit          busy_ok;
    bit          done_long;
    logic        err;
    logic        mis;
    logic [31:0] rdata;
  } obs_t;

  // Reference: access size in bytes, lane replication and extension.
  function automatic void model_txn(
    input bit st, input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] rd,
    output bit legal, output bit fault,
    output logic [3:0] be, output logic [31:0] ewd,
    output logic [31:0] erd);
    int size;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    size  = 1 << f3[1:0];
    off   = int'(a[1:0]);
    legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    fault = CHK && (size <= 4) && ((off % size) != 0);
    if (size > 4) size = 4;
    off  = off - (off % size);
    be   = 4'(((1 << size) - 1) << off);
    ewd  = '0;
    if (st)
      for (int i = 0; i < 4; i++)
        ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    if (size == 4) erd = rd;
    else begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      v = (rd >> (8 * off)) & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
      erd = v;
    end
  endfunction

  // Issues one start and acts as memory; ack_after<0 never acks.
  task automatic drive_txn(
    input bit st, input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] rd,
    input int ack_after, output obs_t ob);
    ob = '{default: 0};
    ob.done_at = -1;
    ob.stable  = 1;
    ob.busy_ok = 1;
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      if (busy !== 1'b1) ob.busy_ok = 0;
      if (done === 1'b1) begin
        ob.done_at = c;
        ob.err   = err;
        ob.mis   = misaligned;
        ob.rdata = rdata_out;
        if (mem_req !== 1'b0) ob.stable = 0;
        break;
      end
      if (mem_req === 1'b1) begin
        if (ob.nreq == 0) begin
          ob.addr = mem_addr; ob.be = mem_be;
          ob.we = mem_we; ob.wdata = mem_wdata;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} !==
                     {ob.addr, ob.be, ob.we, ob.wdata}) begin
          ob.stable = 0;
        end
        ob.nreq++;
        if (ob.nreq == ack_after + 1) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) ob.done_long = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, misaligned, mem_req, mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, err, misaligned, mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_be !== 4'h0) begin
      errors++;
      $display("FAIL reset_addr_be: got %h/%h expected 0/0",
               mem_addr, mem_be);
    end
    checks++;
    if (mem_wdata !== 32'h0 || rdata_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0",
               mem_wdata, rdata_out);
    end
    rst = 1'b0;
    model_rd = '0;
    @(negedge clk);
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          w;
    logic [31:0] eaddr;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[6];
    obs_t ob;
    tbl[0] = '{0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3,
               32'h100, 4'b1111, 32'h0, 32'hDEADBEEF};
    tbl[1] = '{0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1,
               32'h100, 4'b1000, 32'h0, 32'hFFFFFF80};
    tbl[2] = '{0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0,
               32'h100, 4'b1000, 32'h0, 32'h00000080};
    tbl[3] = '{0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 2,
               32'h100, 4'b1100, 32'h0, 32'hFFFF80FF};
    tbl[4] = '{1, 3'b001, 32'h206, 32'h1234ABCD, 32'h55AA55AA, 2,
               32'h204, 4'b1100, 32'hABCDABCD, 32'hFFFF80FF};
    tbl[5] = '{1, 3'b000, 32'h201, 32'h1234ABCD, 32'h0, 0,
               32'h200, 4'b0010, 32'hCDCDCDCD, 32'hFFFF80FF};
    foreach (tbl[i]) begin
      drive_txn(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd,
                tbl[i].rd, tbl[i].w, ob);
      checks++;
      if (ob.done_at != tbl[i].w + 2 || ob.nreq != tbl[i].w + 1) begin
        errors++;
        $display("FAIL dir%0d_timing: got done@%0d req=%0d expected done@%0d req=%0d",
                 i, ob.done_at, ob.nreq, tbl[i].w + 2, tbl[i].w + 1);
      end
      checks++;
      if ({ob.addr, ob.be, ob.we, ob.wdata} !==
          {tbl[i].eaddr, tbl[i].be, tbl[i].st, tbl[i].ewd}) begin
        errors++;
        $display("FAIL dir%0d_bus: got %h %b %b %h expected %h %b %b %h",
                 i, ob.addr, ob.be, ob.we, ob.wdata,
                 tbl[i].eaddr, tbl[i].be, tbl[i].st, tbl[i].ewd);
      end
      checks++;
      if (ob.rdata !== tbl[i].erd || ob.err !== 1'b0 || ob.mis !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_result: got %h err=%b mis=%b expected %h err=0 mis=0",
                 i, ob.rdata, ob.err, ob.mis, tbl[i].erd);
      end
      checks++;
      if (!ob.stable || !ob.busy_ok || ob.done_long) begin
        errors++;
        $display("FAIL dir%0d_handshake: got stable=%0d busy=%0d long=%0d expected 1 1 0",
                 i, ob.stable, ob.busy_ok, ob.done_long);
      end
      if (!tbl[i].st) model_rd = tbl[i].erd;
    end
  endtask

  task automatic test_timeout();
    obs_t ob;
    logic [31:0] rd;
    drive_txn(0, 3'b010, 32'h300, 32'h0, 32'h12345678, -1, ob);
    checks++;
    if (ob.nreq != TO || ob.done_at != TO + 1) begin
      errors++;
      $display("FAIL timeout_timing: got req=%0d done@%0d expected req=%0d done@%0d",
               ob.nreq, ob.done_at, TO, TO + 1);
    end
    checks++;
    if (ob.err !== 1'b1 || ob.rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_result: got err=%b rd=%h expected err=1 rd=0",
               ob.err, ob.rdata);
    end
    model_rd = '0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, mem_req} !== 3'b000 || rdata_out !== 32'h0) begin
        errors++;
        $display("FAIL late_ack: got %b rd=%h expected 000 rd=0",
                 {busy, done, mem_req}, rdata_out);
      end
    end
    mem_ack = 1'b0;
    rd = $urandom;
    drive_txn(0, 3'b010, 32'h304, 32'h0, rd, 1, ob);
    checks++;
    if (ob.done_at != 3 || ob.rdata !== rd || ob.err !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: got done@%0d rd=%h err=%b expected done@3 rd=%h err=0",
               ob.done_at, ob.rdata, ob.err, rd);
    end
    model_rd = rd;
  endtask

  task automatic test_misalign();
    obs_t ob;
    drive_txn(0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, ob);
    if (CHK) begin
      checks++;
      if (ob.done_at != 1 || ob.nreq != 0 || ob.mis !== 1'b1 ||
          ob.err !== 1'b1 || ob.rdata !== model_rd) begin
        errors++;
        $display("FAIL misalign_chk: got done@%0d req=%0d mis=%b err=%b rd=%h expected 1 0 1 1 %h",
                 ob.done_at, ob.nreq, ob.mis, ob.err, ob.rdata, model_rd);
      end
    end else begin
      checks++;
      if (ob.done_at != 2 || ob.addr !== 32'h100 || ob.be !== 4'hF ||
          ob.mis !== 1'b0 || ob.rdata !== 32'h11223344) begin
        errors++;
        $display("FAIL misalign_fix: got done@%0d %h %b mis=%b rd=%h expected 2 100 1111 0 11223344",
                 ob.done_at, ob.addr, ob.be, ob.mis, ob.rdata);
      end
      model_rd = 32'h11223344;
    end
  endtask

  task automatic test_illegal();
    logic [3:0] cases [8] = '{4'b0011, 4'b0110, 4'b0111, 4'b1011,
                              4'b1100, 4'b1101, 4'b1110, 4'b1111};
    obs_t ob;
    foreach (cases[i]) begin
      drive_txn(cases[i][3], cases[i][2:0], $urandom, $urandom,
                $urandom, 0, ob);
      checks++;
      if (ob.done_at != 1 || ob.nreq != 0 || ob.err !== 1'b1 ||
          ob.mis !== 1'b0 || ob.rdata !== model_rd) begin
        errors++;
        $display("FAIL illegal_%b: got done@%0d req=%0d err=%b mis=%b rd=%h expected 1 0 1 0 %h",
                 cases[i], ob.done_at, ob.nreq, ob.err, ob.mis, ob.rdata,
                 model_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t ob;
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got req=%b expected 1", mem_req);
    end
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    checks++;
    if ({mem_req, busy, done} !== 3'b000 || rdata_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got %b rd=%h expected 000 rd=0",
               {mem_req, busy, done}, rdata_out);
    end
    model_rd = '0;
    @(negedge clk);
    drive_txn(0, 3'b101, 32'h402, 32'h0, 32'hC0DE9ABC, 0, ob);
    checks++;
    if (ob.done_at != 2 || ob.rdata !== 32'h0000C0DE || ob.be !== 4'b1100) begin
      errors++;
      $display("FAIL rst_mid_post: got done@%0d rd=%h be=%b expected 2 0000c0de 1100",
               ob.done_at, ob.rdata, ob.be);
    end
    model_rd = 32'h0000C0DE;
  endtask

  task automatic test_busy_ignore();
    int nreq = 0;
    int dn = 0;
    bit bad = 0;
    bit late = 0;
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h500; start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 10; c++) begin
      if (mem_req === 1'b1) begin
        nreq++;
        if (mem_addr !== 32'h500 || mem_we !== 1'b0) bad = 1;
      end
      if (done === 1'b1) dn++;
      if (c >= 5 && (busy !== 1'b0 || mem_req !== 1'b0)) late = 1;
      start = (c == 2) || (done === 1'b1);
      is_store = 1'b1; addr = 32'h600;
      mem_ack = (nreq == 3) && (mem_req === 1'b1);
      mem_rdata = 32'hCAFE0001;
      @(negedge clk);
    end
    start = 1'b0; mem_ack = 1'b0;
    checks++;
    if (nreq != 3 || dn != 1 || bad || late) begin
      errors++;
      $display("FAIL busy_ignore: got req=%0d done=%0d bad=%0d late=%0d expected 3 1 0 0",
               nreq, dn, bad, late);
    end
    checks++;
    if (rdata_out !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL busy_ignore_rd: got %h expected cafe0001", rdata_out);
    end
    model_rd = 32'hCAFE0001;
  endtask

  task automatic test_random();
    obs_t ob;
    bit st;
    logic [2:0] f3;
    logic [31:0] a, wd, rd, ewd, erd;
    logic [3:0] be;
    bit legal, fault;
    int w, edone, ereq;
    logic eerr, emis;
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom); f3 = 3'($urandom);
      a = $urandom; wd = $urandom; rd = $urandom;
      w = (!st && $urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      model_txn(st, f3, a, wd, rd, legal, fault, be, ewd, erd);
      if (!legal || fault) begin
        edone = 1; ereq = 0; eerr = 1; emis = legal && fault;
      end else if (w < 0) begin
        edone = TO + 1; ereq = TO; eerr = 1; emis = 0; model_rd = '0;
      end else begin
        edone = w + 2; ereq = w + 1; eerr = 0; emis = 0;
        if (!st) model_rd = erd;
      end
      drive_txn(st, f3, a, wd, rd, w, ob);
      checks++;
      if (ob.done_at != edone || ob.nreq != ereq) begin
        errors++;
        $display("FAIL rnd%0d_timing: got done@%0d req=%0d expected done@%0d req=%0d",
                 n, ob.done_at, ob.nreq, edone, ereq);
      end
      checks++;
      if (ob.err !== eerr || ob.mis !== emis || ob.rdata !== model_rd) begin
        errors++;
        $display("FAIL rnd%0d_result: got err=%b mis=%b rd=%h expected err=%b mis=%b rd=%h",
                 n, ob.err, ob.mis, ob.rdata, eerr, emis, model_rd);
      end
      if (ereq > 0) begin
        checks++;
        if ({ob.addr, ob.be, ob.we, ob.wdata} !==
            {a[31:2], 2'b00, be, st, ewd} || !ob.stable) begin
          errors++;
          $display("FAIL rnd%0d_bus: got %h %b %b %h stable=%0d expected %h %b %b %h stable=1",
                   n, ob.addr, ob.be, ob.we, ob.wdata, ob.stable,
                   {a[31:2], 2'b00}, be, st, ewd);
        end
      end
      checks++;
      if (!ob.busy_ok || ob.done_long) begin
        errors++;
        $display("FAIL rnd%0d_busy: got busy_ok=%0d long=%0d expected 1 0",
                 n, ob.busy_ok, ob.done_long);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_misalign();
    test_illegal();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of the ALU in the minimal RISC-V datapath.
- Takes the ALU result as the effective address and rs2 as store data, and runs one data-memory transaction per request over a req/ack handshake.
- Formats store lanes and byte enables, and sign- or zero-extends load data for writeback.
- Stalls the core through busy until the access completes or times out.

Parameters:
- ACK_TIMEOUT, 15: cycles mem_req may stay high without mem_ack before the access is aborted. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RISC-V width/sign field
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: illegal funct3, timeout, or misalign
- rdata_out  out  32  formatted load result; held until the next accepted start
- misaligned  out  1  valid with done; see Optional Feature
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data; valid with mem_ack
- mem_ack  in  1  memory accept/complete

Behaviour:
- Reset values: every output 0, state IDLE, all latched fields and the timeout counter cleared.
- Reset mid-transaction abandons the access; mem_req is low the cycle after reset. An mem_ack arriving in IDLE is ignored.
- State machine:
  - IDLE -> ACCESS on start. Latch is_store, funct3, addr and wdata; later input changes are ignored.
  - IDLE -> DONE on start with an illegal funct3 (loads 011/110/111, stores 1xx/011). No memory request is issued; err=1.
  - ACCESS: mem_req=1, and mem_we/mem_addr/mem_be/mem_wdata are stable for the whole state. On mem_ack, capture and format mem_rdata for loads, then -> DONE.
  - ACCESS timeout: if ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT without mem_ack, drop mem_req, set err=1, rdata_out=0, then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE. A start during DONE is ignored.
- Latency: start at cycle N, mem_req at N+1. mem_ack at cycle N+k (k>=1) gives done at N+k+1. Minimum start-to-done is 2 cycles.
- Timeout counter: cleared on entering ACCESS, incremented each ACCESS cycle without ack. mem_ack arriving in the same cycle the count reaches the limit counts as success.
- start while busy is ignored; there is no queueing.
- Byte enables, with o = addr[1:0]:
  - byte accesses: 4'b0001<<o
  - half accesses: 4'b0011<<{o[1],1'b0}
  - word accesses: 4'b1111
  - Loads drive mem_be the same way as stores.
- mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata; 0 for loads.
- Load formatting: shift mem_rdata right by 8*o for bytes, or 16*o[1] for halves. Then:
  - LB, LH: sign-extend
  - LBU, LHU: zero-extend
  - LW: pass unchanged
- Stores leave rdata_out unchanged.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request. The unit goes IDLE -> DONE with misaligned=1, err=1 and rdata_out unchanged.
- Undefined: misaligned is tied to 0. Offending low address bits are forced to zero per access size (half: o[0]=0; word: o=0) and the access proceeds normally.

Test Plan:
- LW addr=0x100, memory acks after 3 wait cycles with 0xDEADBEEF -> mem_addr=0x100, mem_be=1111, done at start+5, rdata_out=0xDEADBEEF, err=0.
- LB addr=0x103 with mem_rdata=0x80FF_1234 -> mem_be=1000, rdata_out=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x102 -> 0xFFFF80FF.
- SH addr=0x206 wdata=0x1234ABCD -> mem_we=1, mem_addr=0x204, mem_be=1100, mem_wdata=0xABCDABCD. SB addr=0x201 -> mem_be=0010.
- LW with no ack, ACK_TIMEOUT=15 -> mem_req high 15 cycles then low; done with err=1, rdata_out=0. A later ack is ignored, and a new start is accepted.
- LW addr=0x102. With LSU_MISALIGN_CHECK_EN defined -> no mem_req, done at start+1, misaligned=1, err=1. Without it -> mem_addr=0x100, mem_be=1111, misaligned=0.
- rst asserted during ACCESS -> next cycle mem_req=0, busy=0, done=0. A start 2 cycles later completes normally. A start during busy or DONE is ignored, with no second request.
